// File: rtl/mcp48x2_pkg.sv
// mcp48x2_pkg: shared FSM states, MCP48x2 frame layout and DAC timing minima
package mcp48x2_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_LS_WAIT,
    S_LDAC_PULSE
  } state_e;
  localparam int FRAME_W   = 16;
  localparam int CH_BIT    = 15;
  localparam int GA_BIT    = 13;
  localparam int SHDN_BIT  = 12;
  localparam int T_CSSR_NS = 15;
  localparam int T_LS_NS   = 40;
  localparam int T_LD_NS   = 100;
  // Bit 14 is "don't care" on the MCP4822 and is always sent as 0.
  function automatic logic [FRAME_W-1:0] frame_word(input logic ch, input logic ga, input logic [11:0] data);
    logic [FRAME_W-1:0] w;
    w = {4'b0000, data};
    w[CH_BIT] = ch;
    w[GA_BIT] = ga;
    w[SHDN_BIT] = 1'b1;
    return w;
  endfunction
endpackage

// File: rtl/spi_mcp4822_dac_if.sv
// spi_mcp4822_dac_if: sample input strobe plus SPI/LDAC pins and status of the DAC writer
interface spi_mcp4822_dac_if;
  logic [11:0] i_DATA;
  logic        i_CH;
  logic        i_DV;
  logic        MOSI;
  logic        SCK;
  logic        CS;
  logic        LDAC;
  logic        BUSY;
  logic        OVERRUN;
  modport master (input i_DATA, i_CH, i_DV, output MOSI, SCK, CS, LDAC, BUSY, OVERRUN);
  modport slave (output i_DATA, i_CH, i_DV, input MOSI, SCK, CS, LDAC, BUSY, OVERRUN);
endinterface

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: mode-0 SCK, high half first, with strobes on the cycle before each fall/rise
module spi_sck_gen #(
  parameter int SCK_HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);
  localparam int PW = SCK_HALF > 1 ? $clog2(SCK_HALF) : 1;
  logic [PW-1:0] phase_q, phase_d;
  logic low_q, low_d, last;
  always_comb begin
    last = phase_q == PW'(SCK_HALF - 1);
    phase_d = (!en || last) ? '0 : phase_q + 1'b1;
    low_d = en && (last ? !low_q : low_q);
    sck = en && !low_q;
    fall = en && !low_q && last;
    rise = en && low_q && last;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
      low_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      low_q <= low_d;
    end
  end
endmodule

// File: rtl/spi_mcp4822_dac.sv
// spi_mcp4822_dac: write-only SPI master framing 12-bit samples for an MCP4822 and pulsing LDAC
module spi_mcp4822_dac
  import mcp48x2_pkg::*;
#(
  parameter int SCK_HALF = 4,
  parameter int T_SETUP  = 4,
  parameter int T_HOLD   = 2,
  parameter int T_LS     = 6,
  parameter int T_LDAC   = 13,
  parameter bit GAIN_1X  = 1'b1
) (
  input logic clk,
  input logic rst_n,
  spi_mcp4822_dac_if.master io
);
  localparam int T_A   = T_SETUP > T_HOLD ? T_SETUP : T_HOLD;
  localparam int T_B   = T_LS > T_LDAC ? T_LS : T_LDAC;
  localparam int T_MAX = T_A > T_B ? T_A : T_B;
  localparam int CW    = $clog2(T_MAX + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, tlim;
  logic [3:0] bit_q, bit_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [12:0] pbuf_q, pbuf_d, sample;
  logic pend_q, pend_d, ovr_q, ovr_d;
  logic busy, launch, store, cnt_done, cs_on, sck, rise, fall;
  spi_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck (
    .clk(clk), .rst_n(rst_n), .en(state_q == S_SHIFT), .sck(sck), .rise(rise), .fall(fall)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      pbuf_q <= '0;
      pend_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      pbuf_q <= pbuf_d;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
    end
  end
  always_comb begin
    tlim = state_q == S_CS_SETUP ? CW'(T_SETUP - 1) :
           state_q == S_CS_HOLD  ? CW'(T_HOLD - 1)  :
           state_q == S_LS_WAIT  ? CW'(T_LS - 1)    : CW'(T_LDAC - 1);
    cnt_done = cnt_q == tlim;
    state_d = state_q;
    case (state_q)
      S_IDLE:       state_d = (pend_q || io.i_DV) ? S_CS_SETUP : S_IDLE;
      S_CS_SETUP:   state_d = cnt_done ? S_SHIFT : S_CS_SETUP;
      S_SHIFT:      state_d = (rise && bit_q == 4'd15) ? S_CS_HOLD : S_SHIFT;
      S_CS_HOLD:    state_d = cnt_done ? S_LS_WAIT : S_CS_HOLD;
      S_LS_WAIT:    state_d = cnt_done ? S_LDAC_PULSE : S_LS_WAIT;
      S_LDAC_PULSE: state_d = cnt_done ? S_IDLE : S_LDAC_PULSE;
      default:      state_d = S_IDLE;
    endcase
    // Counters restart on every state change, so they never run past their range.
    cnt_d = (state_d != state_q || state_q == S_IDLE || state_q == S_SHIFT) ? '0 : cnt_q + 1'b1;
    bit_d = state_d != S_SHIFT ? '0 : rise ? bit_q + 1'b1 : bit_q;
  end
  always_comb begin
    busy = state_q != S_IDLE;
    launch = !busy && (pend_q || io.i_DV);
    store = io.i_DV && (busy || pend_q);
    sample = pend_q ? pbuf_q : {io.i_CH, io.i_DATA};
    sh_d = launch ? frame_word(sample[12], GAIN_1X, sample[11:0]) : fall ? {sh_q[FRAME_W-2:0], 1'b0} : sh_q;
    pend_d = store ? 1'b1 : launch ? 1'b0 : pend_q;
    pbuf_d = store ? {io.i_CH, io.i_DATA} : pbuf_q;
    ovr_d = io.i_DV && busy && pend_q;
  end
  always_comb begin
    cs_on = state_q == S_CS_SETUP || state_q == S_SHIFT || state_q == S_CS_HOLD;
    io.CS = !cs_on;
    io.SCK = sck;
    io.MOSI = cs_on && sh_q[FRAME_W-1];
    io.LDAC = state_q != S_LDAC_PULSE;
    io.BUSY = busy;
    io.OVERRUN = ovr_q;
  end
endmodule

// File: tb/tb_spi_mcp4822_dac.sv
// tb_spi_mcp4822_dac: directed scenarios for the MCP4822 writer, gain 1x (dut_a) and 2x (dut_b)
module tb_spi_mcp4822_dac;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic dv = 1'b0;
  logic ch = 1'b0;
  logic [11:0] data = '0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_mcp4822_dac_if ifa ();
  spi_mcp4822_dac_if ifb ();
  assign ifa.i_DATA = data;
  assign ifa.i_CH = ch;
  assign ifa.i_DV = dv & ~sel;
  assign ifb.i_DATA = data;
  assign ifb.i_CH = ch;
  assign ifb.i_DV = dv & sel;
  spi_mcp4822_dac #(.GAIN_1X(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .io(ifa));
  spi_mcp4822_dac #(.GAIN_1X(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .io(ifb));

  logic m_mosi, m_sck, m_cs, m_ldac, m_busy, m_ov;
  assign m_mosi = sel ? ifb.MOSI : ifa.MOSI;
  assign m_sck = sel ? ifb.SCK : ifa.SCK;
  assign m_cs = sel ? ifb.CS : ifa.CS;
  assign m_ldac = sel ? ifb.LDAC : ifa.LDAC;
  assign m_busy = sel ? ifb.BUSY : ifa.BUSY;
  assign m_ov = sel ? ifb.OVERRUN : ifa.OVERRUN;

  // Pin monitor: reconstructs each frame and its timing from the selected DUT's pins.
  logic prev_cs = 1'b1, prev_ldac = 1'b1, prev_sck = 1'b0, prev_busy = 1'b0, got = 1'b0, gap_on = 1'b0;
  logic [15:0] word = '0, fr_word = '0;
  int cnt_cs = 0, cssr = 0, rises = 0, gap = 0, ldac_cnt = 0, busy_cnt = 0;
  int cs_len = 0, fr_rises = 0, fr_gap = 0, fr_ldac = 0, fr_busy = 0;
  int cs_falls = 0, ldac_falls = 0, frames = 0, ov_cnt = 0, ov_cyc = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, ldac_fall_cyc = 0, busy_fall_cyc = 0, idle_before = 0, cs_gap = 0;
  int min_cssr = 9999, min_gap = 9999, min_ldac = 9999;
  always @(negedge clk) begin
    if (prev_cs && !m_cs) begin
      cs_falls <= cs_falls + 1;
      cnt_cs <= 1;
      cssr <= 1;
      got <= 1'b0;
      rises <= 0;
      cs_fall_cyc <= cyc;
      idle_before <= cyc - busy_fall_cyc;
      cs_gap <= cyc - cs_rise_cyc;
    end else if (!m_cs) begin
      cnt_cs <= cnt_cs + 1;
      if (!got && !m_sck) cssr <= cssr + 1;
    end
    if (m_sck && !prev_sck) begin
      word <= {word[14:0], m_mosi};
      rises <= rises + 1;
      if (!got) begin
        got <= 1'b1;
        if (cssr < min_cssr) min_cssr <= cssr;
      end
    end
    if (m_cs && !prev_cs) begin
      cs_len <= cnt_cs;
      fr_word <= word;
      fr_rises <= rises;
      cs_rise_cyc <= cyc;
      gap <= 1;
      gap_on <= 1'b1;
    end else if (gap_on) begin
      if (m_ldac) gap <= gap + 1;
      else begin
        fr_gap <= gap;
        gap_on <= 1'b0;
        if (gap < min_gap) min_gap <= gap;
      end
    end
    if (!m_ldac) begin
      if (prev_ldac) begin
        ldac_cnt <= 1;
        ldac_falls <= ldac_falls + 1;
        ldac_fall_cyc <= cyc;
      end else ldac_cnt <= ldac_cnt + 1;
    end else if (!prev_ldac) begin
      fr_ldac <= ldac_cnt;
      if (ldac_cnt < min_ldac) min_ldac <= ldac_cnt;
      frames <= frames + 1;
    end
    if (m_busy) busy_cnt <= prev_busy ? busy_cnt + 1 : 1;
    else if (prev_busy) begin
      fr_busy <= busy_cnt;
      busy_fall_cyc <= cyc;
    end
    if (m_ov) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc <= cyc;
    end
    prev_cs <= m_cs;
    prev_ldac <= m_ldac;
    prev_sck <= m_sck;
    prev_busy <= m_busy;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one sample for exactly one edge; returns cyc as seen just after that edge.
  task automatic pulse(input logic c, input logic [11:0] d, output int t);
    dv = 1'b1;
    ch = c;
    data = d;
    @(posedge clk);
    #1;
    t = cyc;
    dv = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (frames < target) begin
      bad++;
      $display("FAIL wait_frames frames=%0d want=%0d", frames, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ifa.CS !== 1'b1) begin bad++; $display("FAIL reset_cs got=%b want=1", ifa.CS); end
    total++; if (ifa.SCK !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want=0", ifa.SCK); end
    total++; if (ifa.MOSI !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", ifa.MOSI); end
    total++; if (ifa.LDAC !== 1'b1) begin bad++; $display("FAIL reset_ldac got=%b want=1", ifa.LDAC); end
    total++; if (ifa.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", ifa.BUSY); end
    total++; if (ifa.OVERRUN !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", ifa.OVERRUN); end
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_single();
    int t0, f0, o0;
    f0 = frames;
    o0 = ov_cnt;
    pulse(1'b0, 12'hA5C, t0);
    wait_frames(f0 + 1, 400);
    total++; if (fr_word !== 16'h3A5C) begin bad++; $display("FAIL single_word got=%h want=3a5c", fr_word); end
    total++; if (fr_rises != 16) begin bad++; $display("FAIL single_rises got=%0d want=16", fr_rises); end
    total++; if (cs_fall_cyc != t0) begin bad++; $display("FAIL single_cs_start got=%0d want=%0d", cs_fall_cyc, t0); end
    total++; if (cs_len != 134) begin bad++; $display("FAIL single_cs_len got=%0d want=134", cs_len); end
    total++; if (fr_gap != 6) begin bad++; $display("FAIL single_ls_gap got=%0d want=6", fr_gap); end
    total++; if (ldac_fall_cyc != t0 + 140) begin bad++; $display("FAIL single_ldac_start got=%0d want=%0d", ldac_fall_cyc, t0 + 140); end
    total++; if (fr_ldac != 13) begin bad++; $display("FAIL single_ldac_len got=%0d want=13", fr_ldac); end
    total++; if (busy_fall_cyc != t0 + 153) begin bad++; $display("FAIL single_busy_end got=%0d want=%0d", busy_fall_cyc, t0 + 153); end
    total++; if (ov_cnt != o0) begin bad++; $display("FAIL single_ovr got=%0d want=%0d", ov_cnt, o0); end
    idle(5);
  endtask

  task automatic test_gain2x();
    int t0, f0;
    sel = 1'b1;
    idle(3);
    f0 = frames;
    pulse(1'b1, 12'hFFF, t0);
    wait_frames(f0 + 1, 400);
    total++; if (fr_word !== 16'h9FFF) begin bad++; $display("FAIL gain2x_word got=%h want=9fff", fr_word); end
    total++; if (fr_busy != 153) begin bad++; $display("FAIL gain2x_busy_len got=%0d want=153", fr_busy); end
    total++; if (ifa.CS !== 1'b1) begin bad++; $display("FAIL gain2x_other_cs got=%b want=1", ifa.CS); end
    sel = 1'b0;
    idle(3);
  endtask

  task automatic test_back_to_back();
    int t0, t1, f0, o0;
    f0 = frames;
    o0 = ov_cnt;
    pulse(1'b0, 12'h123, t0);
    idle(19);
    pulse(1'b0, 12'h111, t1);
    wait_frames(f0 + 2, 800);
    total++; if (fr_word !== 16'h3111) begin bad++; $display("FAIL b2b_word got=%h want=3111", fr_word); end
    total++; if (idle_before != 1) begin bad++; $display("FAIL b2b_idle got=%0d want=1", idle_before); end
    total++; if (cs_gap != 20) begin bad++; $display("FAIL b2b_cs_gap got=%0d want=20", cs_gap); end
    total++; if (cs_fall_cyc != t0 + 154) begin bad++; $display("FAIL b2b_start got=%0d want=%0d", cs_fall_cyc, t0 + 154); end
    total++; if (ov_cnt != o0) begin bad++; $display("FAIL b2b_ovr got=%0d want=%0d", ov_cnt, o0); end
    idle(5);
  endtask

  task automatic test_overrun();
    int t0, t1, t2, f0, o0;
    f0 = frames;
    o0 = ov_cnt;
    pulse(1'b0, 12'h456, t0);
    idle(19);
    pulse(1'b0, 12'h111, t1);
    idle(19);
    pulse(1'b0, 12'h222, t2);
    wait_frames(f0 + 2, 800);
    total++; if (ov_cnt != o0 + 1) begin bad++; $display("FAIL ovr_count got=%0d want=%0d", ov_cnt - o0, 1); end
    total++; if (ov_cyc != t0 + 40) begin bad++; $display("FAIL ovr_time got=%0d want=%0d", ov_cyc, t0 + 40); end
    total++; if (fr_word !== 16'h3222) begin bad++; $display("FAIL ovr_word got=%h want=3222", fr_word); end
    idle(250);
    total++; if (frames != f0 + 2) begin bad++; $display("FAIL ovr_frames got=%0d want=%0d", frames, f0 + 2); end
  endtask

  task automatic test_reset_mid();
    int t0, t1, c0, l0;
    pulse(1'b0, 12'hABC, t0);
    idle(19);
    pulse(1'b1, 12'h111, t1);
    idle(42);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++; if (ifa.CS !== 1'b1) begin bad++; $display("FAIL abort_cs got=%b want=1", ifa.CS); end
    total++; if (ifa.SCK !== 1'b0) begin bad++; $display("FAIL abort_sck got=%b want=0", ifa.SCK); end
    total++; if (ifa.MOSI !== 1'b0) begin bad++; $display("FAIL abort_mosi got=%b want=0", ifa.MOSI); end
    total++; if (ifa.LDAC !== 1'b1) begin bad++; $display("FAIL abort_ldac got=%b want=1", ifa.LDAC); end
    total++; if (ifa.BUSY !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", ifa.BUSY); end
    rst_n = 1'b1;
    idle(2);
    c0 = cs_falls;
    l0 = ldac_falls;
    idle(300);
    total++; if (cs_falls != c0) begin bad++; $display("FAIL abort_pending got=%0d want=%0d", cs_falls, c0); end
    total++; if (ldac_falls != l0) begin bad++; $display("FAIL abort_ldac_pulse got=%0d want=%0d", ldac_falls, l0); end
  endtask

  task automatic test_timing();
    total++; if (min_cssr * 8 < 32) begin bad++; $display("FAIL timing_cssr got=%0dns want>=32ns", min_cssr * 8); end
    total++; if (min_gap * 8 < 48) begin bad++; $display("FAIL timing_ls got=%0dns want>=48ns", min_gap * 8); end
    total++; if (min_ldac * 8 < 104) begin bad++; $display("FAIL timing_ldac got=%0dns want>=104ns", min_ldac * 8); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gain2x();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
